soda_datapath: RTL and testbench
================================

# soda_datapath

Coin-side datapath for the soda dispenser, feeding the soda control FSM. Synchronizes and debounces the coin sensor, emits a one-cycle coin-detect pulse `c` with a captured coin value, and accumulates the inserted total on the FSM's `tot_ld`/`tot_clr` commands. Produces the `tot_lt_s` compare, the dispense-duration counter `count` (cleared by `rst_counter`), and the power-up `init_done` flag.

## Interface
- PRICE, 8'd75, soda price in cents; `tot_lt_s` compares against it
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required to change the debounced coin level (≥1)
- TICK_DIV, 10, clock cycles per `count` increment (≥1)
- INIT_CYCLES, 8, cycles after reset release before `init_done` asserts (≥1)

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- coin_btn  in  1  raw coin sensor, asynchronous, may bounce
- coin_sel  in  2  coin type at insertion: 00=5, 01=10, 10=25, 11=100 cents
- tot_ld  in  1  add captured coin value `a` to total (from FSM)
- tot_clr  in  1  clear total (from FSM)
- rst_counter  in  1  clear dispense counter and prescaler (from FSM)
- c  out  1  one-cycle coin-detected pulse
- a  out  8  captured value of the last detected coin, in cents
- total  out  8  accumulated total, in cents
- tot_lt_s  out  1  1 when total < PRICE
- count  out  4  dispense duration counter, saturates at 15
- init_done  out  1  1 once INIT_CYCLES have elapsed since reset release

## Operation
- Reset values: c=0, a=0, total=0, tot_lt_s=1 (PRICE>0), count=0, init_done=0. Synchronizer, debounce counter, prescaler, and init counter are cleared; debounced level is 0.
- Synchronizer: 2 flops on coin_btn; only the second flop feeds logic.
- Debounce: counter increments while synced ≠ debounced and resets to 0 when they are equal. When it reaches DEBOUNCE_CYCLES, debounced takes the synced value and the counter clears.
- Coin FSM states:
  - IDLE: on debounced rising, go to PULSE and capture a from coin_sel, decoded on that edge.
  - PULSE: c=1 for exactly one cycle, then go to WAIT_REL.
  - WAIT_REL: when debounced is 0, go to IDLE.
  - A held button produces one pulse only; a bounce shorter than DEBOUNCE_CYCLES produces none.
- Accumulator:
  - tot_clr has priority over tot_ld; both asserted gives total=0.
  - tot_ld: total ← total + a, saturating at 255; no wrap.
  - tot_lt_s is combinational from the total register and PRICE (unsigned).
- Dispense counter:
  - rst_counter=1: count=0, prescaler=0.
  - Otherwise the prescaler counts 0..TICK_DIV−1. On wrap, count increments, holding at 15.
  - count runs freely whenever rst_counter=0; the FSM is responsible for holding it in reset outside dispense.
- init_done: init counter runs from reset release. init_done rises when it reaches INIT_CYCLES, then holds at 1 until rst. The counter stops at its terminal value.
- rst asserted mid-operation returns every output to its reset value on the next edge, with no residual c pulse.

## Timing
- c latency for a clean step of coin_btn, where edge 0 is the first edge sampling it high:
  - synced high after edge 1.
  - debounced rises at edge 1+DEBOUNCE_CYCLES.
  - c is high for the cycle following edge 2+DEBOUNCE_CYCLES.
  - With defaults, c is high after edge 6.
- a is valid no later than the cycle in which c=1 and stable until the next detected coin.
- total updates on the edge sampling tot_ld. tot_lt_s reflects the new total in the same cycle total changes, with no extra latency.
- count first reaches 1 TICK_DIV edges after rst_counter deasserts, and reaches 15 after 15·TICK_DIV edges.
- init_done is 1 after the INIT_CYCLES-th edge following the edge where rst was sampled low.

## Test plan
- Reset/init: hold rst 5 cycles, then release → all outputs at reset values; init_done=0 for 7 cycles and rises after the 8th edge.
- Clean coin: coin_btn 0→1 held 20 cycles with coin_sel=10 → exactly one c pulse, high after edge 6; a=25; no second pulse on release.
- Bounce rejection: coin_btn toggles 1,0,1,0 every cycle, then stays 0 → c never asserts; debounced stays 0.
- Accumulate: three quarters, each followed by a tot_ld pulse → total 25, 50, 75; tot_lt_s 1, 1, 0. Then tot_ld and tot_clr together → total=0, tot_lt_s=1.
- Saturation: three 100-cent coins, each loaded → total 100, 200, 255 (saturated, no wrap).
- Dispense counter: rst_counter 1→0 → count=1 after 10 edges and 15 after 150 edges, then holds 15. rst_counter=1 mid-count → count=0 on the next edge.

Source files
------------

// File: rtl/soda_datapath_if.sv
// soda_datapath_if: coin, total and dispense signals shared by the soda datapath and its control FSM.
interface soda_datapath_if;
  logic       coin_btn;
  logic [1:0] coin_sel;
  logic       tot_ld;
  logic       tot_clr;
  logic       rst_counter;
  logic       c;
  logic [7:0] a;
  logic [7:0] total;
  logic       tot_lt_s;
  logic [3:0] count;
  logic       init_done;
  modport master (
    output coin_btn, coin_sel, tot_ld, tot_clr, rst_counter,
    input  c, a, total, tot_lt_s, count, init_done
  );
  modport slave (
    input  coin_btn, coin_sel, tot_ld, tot_clr, rst_counter,
    output c, a, total, tot_lt_s, count, init_done
  );
endinterface

// File: rtl/soda_datapath.sv
// soda_datapath: coin sync/debounce/detect, saturating total accumulator, dispense counter and init flag.
module soda_datapath #(
  parameter logic [7:0] PRICE           = 8'd75,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         TICK_DIV        = 10,
  parameter int         INIT_CYCLES     = 8
) (
  input logic           clk,
  input logic           rst,
  soda_datapath_if.slave dp_if
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_N   = DW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] INIT_N  = IW'(INIT_CYCLES);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PULSE    = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;
  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
  logic [1:0]    state_q, state_d;
  logic [7:0]    a_q, a_d, coin_val;
  logic [7:0]    total_q, total_d;
  logic [8:0]    sum;
  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;
  logic [3:0]    count_q, count_d;
  logic [IW-1:0] icnt_q, icnt_d;
  always_comb begin
    dcnt_inc = dcnt_q + 1'b1;
    deb_d    = (sync_q[1] != deb_q && dcnt_inc == DEB_N) ? sync_q[1] : deb_q;
    dcnt_d   = (sync_q[1] == deb_q || dcnt_inc == DEB_N) ? '0 : dcnt_inc;
    // IDLE with a high debounced level can only follow a rising edge, since WAIT_REL waits for release.
    state_d  = state_q == IDLE  ? (deb_q ? PULSE : IDLE) :
               state_q == PULSE ? WAIT_REL :
               (deb_q ? WAIT_REL : IDLE);
    coin_val = dp_if.coin_sel == 2'b00 ? 8'd5  :
               dp_if.coin_sel == 2'b01 ? 8'd10 :
               dp_if.coin_sel == 2'b10 ? 8'd25 : 8'd100;
    a_d      = (state_q == IDLE && deb_q) ? coin_val : a_q;
    sum      = {1'b0, total_q} + {1'b0, a_q};
    total_d  = dp_if.tot_clr ? 8'd0 :
               dp_if.tot_ld  ? (sum[8] ? 8'hff : sum[7:0]) : total_q;
    pre_wrap = pre_q == PRE_MAX;
    pre_d    = (dp_if.rst_counter || pre_wrap) ? '0 : pre_q + 1'b1;
    count_d  = dp_if.rst_counter ? 4'd0 :
               (pre_wrap && count_q != 4'hf) ? count_q + 4'd1 : count_q;
    icnt_d   = icnt_q == INIT_N ? icnt_q : icnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      state_q <= IDLE;
      a_q     <= '0;
      total_q <= '0;
      pre_q   <= '0;
      count_q <= '0;
      icnt_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], dp_if.coin_btn};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      a_q     <= a_d;
      total_q <= total_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      icnt_q  <= icnt_d;
    end
  end
  assign dp_if.c         = state_q == PULSE;
  assign dp_if.a         = a_q;
  assign dp_if.total     = total_q;
  assign dp_if.tot_lt_s  = total_q < PRICE;
  assign dp_if.count     = count_q;
  assign dp_if.init_done = icnt_q == INIT_N;
endmodule

// File: tb/tb_soda_datapath.sv
// tb_soda_datapath: directed plus randomized checks of soda_datapath against an arithmetic reference model.
module tb_soda_datapath;
  localparam int DEB   = 4;
  localparam int TICK  = 10;
  localparam int INIT  = 8;
  localparam int PRICE = 75;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  soda_datapath_if ifc();
  soda_datapath dut (.clk(clk), .rst(rst), .dp_if(ifc));
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int coin_val [4] = '{5, 10, 25, 100};
  int model_total = 0;
  always @(negedge clk) if (ifc.c === 1'b1) pulses++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
  function automatic int minv(input int x, input int y);
    return x < y ? x : y;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(input logic [1:0] sel, input int hold, input int gap);
    ifc.coin_sel = sel;
    ifc.coin_btn = 1'b1;
    step(hold);
    ifc.coin_btn = 1'b0;
    step(gap);
  endtask
  task automatic load(input logic ld, input logic clr);
    ifc.tot_ld  = ld;
    ifc.tot_clr = clr;
    step(1);
    ifc.tot_ld  = 1'b0;
    ifc.tot_clr = 1'b0;
    model_total = clr ? 0 : ld ? minv(255, model_total + coin_val[ifc.coin_sel]) : model_total;
  endtask
  initial begin
    int p0, sel, n;
    ifc.coin_btn    = 1'b0;
    ifc.coin_sel    = 2'b00;
    ifc.tot_ld      = 1'b0;
    ifc.tot_clr     = 1'b0;
    ifc.rst_counter = 1'b1;
    rst = 1'b1;
    step(5);
    rst = 1'b0;
    chk("rst_c", ifc.c, 0);
    chk("rst_a", ifc.a, 0);
    chk("rst_total", ifc.total, 0);
    chk("rst_lt", ifc.tot_lt_s, 1);
    chk("rst_count", ifc.count, 0);
    chk("rst_init", ifc.init_done, 0);
    for (int i = 1; i <= INIT; i++) begin
      step(1);
      chk($sformatf("init_done_e%0d", i), ifc.init_done, i == INIT);
    end
    step(3);
    chk("init_hold", ifc.init_done, 1);
    // clean quarter: edge 0 is the first edge sampling coin_btn high
    p0 = pulses;
    ifc.coin_sel = 2'b10;
    ifc.coin_btn = 1'b1;
    for (int e = 0; e <= DEB + 3; e++) begin
      step(1);
      chk($sformatf("clean_c_e%0d", e), ifc.c, e == DEB + 2);
      if (e == DEB + 2) chk("clean_a", ifc.a, 25);
    end
    step(20 - (DEB + 4));
    ifc.coin_btn = 1'b0;
    step(15);
    chk("clean_one_pulse", pulses - p0, 1);
    chk("a_stable", ifc.a, 25);
    // bounce rejection
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      ifc.coin_btn = (i % 2 == 0);
      step(1);
    end
    ifc.coin_btn = 1'b0;
    step(12);
    chk("bounce_fixed", pulses - p0, 0);
    p0 = pulses;
    repeat (10) begin
      ifc.coin_btn = 1'b1;
      step($urandom_range(1, DEB - 1));
      ifc.coin_btn = 1'b0;
      step($urandom_range(1, 3));
    end
    step(12);
    chk("bounce_rand", pulses - p0, 0);
    // accumulate quarters, then ld+clr together
    load(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      press(2'b10, 10, 12);
      load(1'b1, 1'b0);
      chk($sformatf("acc_total%0d", k), ifc.total, model_total);
      chk($sformatf("acc_lt%0d", k), ifc.tot_lt_s, model_total < PRICE);
    end
    load(1'b1, 1'b1);
    chk("ldclr_total", ifc.total, 0);
    chk("ldclr_lt", ifc.tot_lt_s, 1);
    // saturation with dollar coins
    for (int k = 0; k < 3; k++) begin
      press(2'b11, 10, 12);
      load(1'b1, 1'b0);
      chk($sformatf("sat_total%0d", k), ifc.total, model_total);
      chk($sformatf("sat_lt%0d", k), ifc.tot_lt_s, model_total < PRICE);
    end
    // randomized coins and FSM commands
    repeat (20) begin
      sel = $urandom_range(0, 3);
      p0 = pulses;
      press(2'(sel), $urandom_range(DEB + 2, 15), $urandom_range(10, 16));
      chk("rnd_pulse", pulses - p0, 1);
      chk("rnd_a", ifc.a, coin_val[sel]);
      n = $urandom_range(0, 3);
      load(n[0], n[1]);
      chk("rnd_total", ifc.total, model_total);
      chk("rnd_lt", ifc.tot_lt_s, model_total < PRICE);
    end
    // dispense counter
    ifc.rst_counter = 1'b0;
    for (int e = 1; e <= 160; e++) begin
      step(1);
      if (e == 1 || e == 9 || e == 10 || e == 11 || e == 149 || e == 150 || e == 160)
        chk($sformatf("count_e%0d", e), ifc.count, minv(15, e / TICK));
    end
    ifc.rst_counter = 1'b1;
    step(1);
    chk("count_clear", ifc.count, 0);
    repeat (4) begin
      ifc.rst_counter = 1'b1;
      step(1);
      ifc.rst_counter = 1'b0;
      n = $urandom_range(1, 200);
      step(n);
      chk($sformatf("count_rnd%0d", n), ifc.count, minv(15, n / TICK));
    end
    // reset during a live coin pulse with nonzero total and count
    press(2'b01, 10, 12);
    load(1'b1, 1'b0);
    ifc.coin_sel = 2'b11;
    ifc.coin_btn = 1'b1;
    step(DEB + 3);
    chk("pre_rst_c", ifc.c, 1);
    rst = 1'b1;
    ifc.coin_btn = 1'b0;
    step(1);
    chk("mid_rst_c", ifc.c, 0);
    chk("mid_rst_a", ifc.a, 0);
    chk("mid_rst_total", ifc.total, 0);
    chk("mid_rst_lt", ifc.tot_lt_s, 1);
    chk("mid_rst_count", ifc.count, 0);
    chk("mid_rst_init", ifc.init_done, 0);
    rst = 1'b0;
    p0 = pulses;
    step(12);
    chk("post_rst_no_pulse", pulses - p0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
